// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access-size and
// exception encodings, FSM state type and the alignment helper.
package mem_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_ILL  = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } mem_state_t;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic addr_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
    logic mis;
    case (len)
      LEN_HALF: mis = addr_lo[0];
      LEN_WORD: mis = (addr_lo != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte-enable generation, store data
// replication across lanes and load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  len,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Decode lanes from access size and low address bits; illegal size drives zeros.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'd0;
    rdata_ext = 32'd0;
    byte_s    = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_s    = rdata_raw[{addr_lo[1], 4'b0000} +: 16];
    case (len)
      LEN_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & byte_s[7]}}, byte_s};
      end
      LEN_HALF: begin
        // addr[0] is ignored here; misaligned halves never reach the bus when checked.
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & half_s[15]}}, half_s};
      end
      LEN_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'd0;
        rdata_ext = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts one load/store request, runs a single
// word-aligned bus transaction with ack/err/timeout handling and returns
// the extended load data or an exception code.
// Optional macro MEM_ALIGN_CHECK_EN: raise AdEL/AdES on misaligned half/word
// accesses without touching the bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_len,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic [31:0] resp_badvaddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_t  state_r, next_s;
  logic        store_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  len_r;
  logic        sign_r;
  logic [7:0]  cnt_r;
  logic        exc_r;
  logic [4:0]  code_r;
  logic [31:0] rdata_raw_r;

  logic        req_exc_s;
  logic        in_bus_s;
  logic        in_resp_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] rdata_ext_s;

  // Address exception detection on the incoming request.
  always_comb begin
    req_exc_s = (req_len == LEN_ILL);
`ifdef MEM_ALIGN_CHECK_EN
    if (addr_misaligned(req_len, req_addr[1:0])) begin
      req_exc_s = 1'b1;
    end else begin
      req_exc_s = (req_len == LEN_ILL);
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          next_s = req_exc_s ? ST_RESP : ST_BUS;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_err || bus_ack || (cnt_r == TO_LAST)) begin
          next_s = ST_RESP;
        end else begin
          next_s = ST_BUS;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r     <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      len_r       <= 2'b00;
      sign_r      <= 1'b0;
      cnt_r       <= 8'd0;
      exc_r       <= 1'b0;
      code_r      <= 5'd0;
      rdata_raw_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            store_r     <= req_store;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            len_r       <= req_len;
            sign_r      <= req_sign;
            cnt_r       <= 8'd0;
            exc_r       <= req_exc_s;
            code_r      <= req_exc_s ? (req_store ? EXC_ADES : EXC_ADEL) : 5'd0;
            rdata_raw_r <= 32'd0;
          end
        end
        ST_BUS: begin
          // err beats ack, ack beats timeout.
          if (bus_err) begin
            exc_r  <= 1'b1;
            code_r <= EXC_DBE;
          end else if (bus_ack) begin
            if (!store_r) begin
              rdata_raw_r <= bus_rdata;
            end
          end else if (cnt_r == TO_LAST) begin
            exc_r  <= 1'b1;
            code_r <= EXC_DBE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  mem_lane_align u_lane (
    .addr_lo   (addr_r[1:0]),
    .len       (len_r),
    .sign      (sign_r),
    .wdata     (wdata_r),
    .rdata_raw (rdata_raw_r),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s)
  );

  assign in_bus_s  = (state_r == ST_BUS);
  assign in_resp_s = (state_r == ST_RESP);

  // Outputs are decoded from registered state only.
  assign req_ready     = (state_r == ST_IDLE);
  assign bus_req       = in_bus_s;
  assign bus_we        = in_bus_s & store_r;
  assign bus_addr      = in_bus_s ? {addr_r[31:2], 2'b00} : 32'd0;
  assign bus_be        = in_bus_s ? be_s : 4'b0000;
  assign bus_wdata     = (in_bus_s && store_r) ? wdata_rep_s : 32'd0;
  assign resp_valid    = in_resp_s;
  assign resp_exc      = in_resp_s & exc_r;
  assign resp_exc_code = (in_resp_s && exc_r) ? code_r : 5'd0;
  assign resp_badvaddr = (in_resp_s && exc_r) ? addr_r : 32'd0;
  assign resp_rdata    = (in_resp_s && !exc_r && !store_r) ? rdata_ext_s : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by
// randomized transactions compared against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 16;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_len = 2'b00;
  logic        req_sign = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] resp_badvaddr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exc_code(resp_exc_code), .resp_badvaddr(resp_badvaddr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: byte enables from size and address.
  function automatic logic [3:0] model_be(input logic [1:0] len, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    if (len == 2'b00) return 4'(1 << a);
    if (len == 2'b01) return 4'(3 << ((a / 2) * 2));
    return 4'hF;
  endfunction

  // Reference model: store data replicated by multiplication.
  function automatic logic [31:0] model_wdata(input logic [1:0] len, input logic [31:0] wd);
    if (len == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (len == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // Reference model: load value shifted down, masked and extended.
  function automatic logic [31:0] model_load(input logic [1:0] len, input logic [31:0] addr,
                                             input bit sign, input logic [31:0] rd);
    logic [31:0] v;
    int a;
    a = int'(addr[1:0]);
    if (len == 2'b00) begin
      v = (rd >> (a * 8)) & 32'hFF;
      if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (len == 2'b01) begin
      v = (rd >> ((a / 2) * 16)) & 32'hFFFF;
      if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // mode: 0=ack, 1=err, 2=err+ack together, 3=no response (timeout)
  task automatic run_txn(input bit store, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] len, input bit sign, input int mode,
                         input int dly, input logic [31:0] rd);
    bit aexc;
    bit bexc;
    int end_cyc;
    aexc = (len == 2'b10) ||
           (ALIGN && ((len == 2'b01 && addr[0]) || (len == 2'b11 && addr[1:0] != 2'b00)));
    check_eq("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = store; req_addr = addr; req_wdata = wd;
    req_len = len; req_sign = sign;
    bus_ack = 1'($urandom_range(0, 1)); bus_err = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_len = 2'($urandom); req_sign = 1'($urandom);
    bus_ack = 1'b0; bus_err = 1'b0;
    if (aexc) begin
      check_eq("aexc_busreq", {31'd0, bus_req}, 32'd0);
      check_eq("aexc_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("aexc_exc", {31'd0, resp_exc}, 32'd1);
      check_eq("aexc_code", {27'd0, resp_exc_code}, store ? 32'd5 : 32'd4);
      check_eq("aexc_bad", resp_badvaddr, addr);
      check_eq("aexc_rdata", resp_rdata, 32'd0);
    end else begin
      end_cyc = (mode == 3) ? TO : dly + 1;
      for (int c = 1; c <= end_cyc; c++) begin
        check_eq("bus_req", {31'd0, bus_req}, 32'd1);
        check_eq("bus_ready", {31'd0, req_ready}, 32'd0);
        check_eq("bus_rvalid", {31'd0, resp_valid}, 32'd0);
        check_eq("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check_eq("bus_be", {28'd0, bus_be}, {28'd0, model_be(len, addr)});
        check_eq("bus_we", {31'd0, bus_we}, {31'd0, store});
        if (store) check_eq("bus_wdata", bus_wdata, model_wdata(len, wd));
        if (c == end_cyc && mode != 3) begin
          bus_ack = (mode != 1); bus_err = (mode != 0); bus_rdata = rd;
        end else begin
          bus_rdata = $urandom;
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
      end
      bexc = (mode != 0);
      check_eq("resp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("resp_busreq", {31'd0, bus_req}, 32'd0);
      check_eq("resp_exc", {31'd0, resp_exc}, {31'd0, bexc});
      if (bexc) begin
        check_eq("resp_code", {27'd0, resp_exc_code}, 32'd7);
        check_eq("resp_bad", resp_badvaddr, addr);
      end
      check_eq("resp_rdata", resp_rdata,
               (!bexc && !store) ? model_load(len, addr, sign, rd) : 32'd0);
    end
    @(negedge clk);
    check_eq("post_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Reset asserted while the bus transaction is outstanding.
  task automatic reset_mid_bus();
    req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h2000_0010; req_len = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_busreq_before", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_busreq_async", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_resp", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_no_bus", {31'd0, bus_req}, 32'd0);
    end
  endtask

  initial begin
    int mode;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset_busreq", {31'd0, bus_req}, 32'd0);
    check_eq("reset_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("reset_be", {28'd0, bus_be}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b11, 1'b0, 0, 0, 32'h0);
    run_txn(1'b0, 32'h0000_0003, 32'h0, 2'b00, 1'b1, 0, 2, 32'h8012_3456);
    run_txn(1'b0, 32'h0000_0003, 32'h0, 2'b00, 1'b0, 0, 1, 32'h8012_3456);
    run_txn(1'b1, 32'h0000_0002, 32'h0000_ABCD, 2'b01, 1'b0, 0, 3, 32'h0);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 2'b11, 1'b0, 3, 0, 32'h0);
    run_txn(1'b0, 32'h0000_0044, 32'h0, 2'b11, 1'b0, 2, 4, 32'h1234_5678);
    run_txn(1'b0, 32'h0000_0046, 32'h0, 2'b01, 1'b1, 0, TO - 1, 32'hF00D_9ABC);
    run_txn(1'b1, 32'h0000_0048, 32'h55, 2'b00, 1'b0, 1, 0, 32'h0);
    run_txn(1'b0, 32'h0000_0050, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
    run_txn(1'b1, 32'h0000_0054, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
    run_txn(1'b0, 32'h0000_0001, 32'h0, 2'b11, 1'b0, 0, 0, 32'hCAFE_F00D);
    reset_mid_bus();

    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 9);
      mode = (mode < 6) ? 0 : (mode == 6) ? 1 : (mode == 7) ? 2 : (mode == 8) ? 3 : 0;
      run_txn(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), mode,
              $urandom_range(0, TO - 1), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
